// File: rtl/aes_sub_shift_rows.sv
// aes_sub_shift_rows
//   AES round datapath stage: SubBytes through four shared pipelined sboxes
//   (one column per cycle), result capture, then ShiftRows.
//
//   Optional build macro: AES_SUB_SHIFT_ROWS_SHIFTROWS_EN
//     defined   -> out_state = ShiftRows(SubBytes(in_state))
//     undefined -> out_state = SubBytes(in_state), bytes in input order
//
//   Ports
//     clk        clock
//     rst        asynchronous reset, active-high
//     in_valid   input state valid
//     in_ready   block can accept a state (IDLE only)
//     in_state   128-bit state, byte i = in_state[127-8i -: 8], column-major
//     out_valid  output state valid (DONE)
//     out_ready  downstream accepts
//     out_state  result, same byte order as in_state
//     busy       high in any state other than IDLE
//
//   state | meaning
//   IDLE  | waiting for an input state, in_ready=1
//   FEED  | driving column cnt_q into the sboxes, 4 cycles
//   DRAIN | waiting for tagged sbox results to emerge and be captured
//   DONE  | out_valid=1, holding out_state until accepted

// Pipelined AES sbox: table lookup followed by LAT-1 further register stages.
// y reflects an x sampled LAT-1 edges earlier; registers are deliberately not
// reset, the caller tags valid data.
module aes_sbox_pipe #(
  parameter int LAT = 6
) (
  input  logic       clk,
  input  logic [7:0] x,
  output logic [7:0] y
);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [7:0] stage_q [LAT];

  // Byte x sits at bit offset 8*(255-x) of the packed table, i.e. {~x,3'b0}.
  always_ff @(posedge clk) begin
    stage_q[0] <= SBOX_TBL[{~x, 3'b000} +: 8];
    for (int i = 1; i < LAT; i++) begin
      stage_q[i] <= stage_q[i-1];
    end
  end

  assign y = stage_q[LAT-1];

endmodule

module aes_sub_shift_rows #(
  parameter int SBOX_LAT = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t        state_q;
  logic [127:0]  st_q;
  logic [127:0]  sub_q;
  logic [1:0]    cnt_q;

  logic [SBOX_LAT-1:0] tag_v_q;
  logic [1:0]          tag_col_q [SBOX_LAT];

  logic [31:0] col_word;
  logic [7:0]  sbox_x [4];
  logic [7:0]  sbox_y [4];
  logic        tag_exit;
  logic [1:0]  exit_col;

  // Column c occupies bits [127-32c -: 32], i.e. base offset 32*(3-c).
  assign col_word = st_q[{~cnt_q, 5'b00000} +: 32];

  for (genvar r = 0; r < 4; r++) begin : g_lane
    assign sbox_x[r] = col_word[31-8*r -: 8];
    aes_sbox_pipe #(.LAT(SBOX_LAT)) u_sbox (
      .clk (clk),
      .x   (sbox_x[r]),
      .y   (sbox_y[r])
    );
  end

  assign tag_exit = tag_v_q[SBOX_LAT-1];
  assign exit_col = tag_col_q[SBOX_LAT-1];

  // Tags travel alongside the sbox data so the capture knows which column
  // is emerging; clearing them on reset masks stale sbox contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_v_q <= '0;
      for (int i = 0; i < SBOX_LAT; i++) tag_col_q[i] <= '0;
    end else begin
      tag_v_q[0]   <= (state_q == FEED);
      tag_col_q[0] <= cnt_q;
      for (int i = 1; i < SBOX_LAT; i++) begin
        tag_v_q[i]   <= tag_v_q[i-1];
        tag_col_q[i] <= tag_col_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      st_q      <= '0;
      sub_q     <= '0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (tag_exit) begin
        for (int c = 0; c < 4; c++) begin
          if (exit_col == 2'(c)) begin
            for (int r = 0; r < 4; r++) begin
              sub_q[127-8*(4*c+r) -: 8] <= sbox_y[r];
            end
          end
        end
      end

      case (state_q)
        IDLE: begin
          if (in_valid) begin
            st_q     <= in_state;
            cnt_q    <= '0;
            state_q  <= FEED;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        FEED: begin
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_q <= DRAIN;
        end
        DRAIN: begin
          if (tag_exit && exit_col == 2'd3) begin
            state_q   <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef AES_SUB_SHIFT_ROWS_SHIFTROWS_EN
  // Output (row r, col c) takes substituted (row r, col (c+r) mod 4).
  logic [127:0] shifted;
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shifted[127-8*(4*c+r) -: 8] = sub_q[127-8*(4*((c+r)%4)+r) -: 8];
    end
  end
  assign out_state = shifted;
`else
  assign out_state = sub_q;
`endif

endmodule

// File: doc/aes_sub_shift_rows.md
Name: aes_sub_shift_rows

Overview:
- AES round datapath stage feeding and consuming the pipelined sbox (6-register pipeline, no reset, one byte per cycle per instance).
- Accepts a 128-bit state and pushes it through 4 shared sbox instances, one column per cycle.
- Collects the substituted bytes, applies ShiftRows, and presents the result to the MixColumns/AddRoundKey stage over a valid/ready handshake.

Parameters:
- SBOX_LAT, 6: sbox pipeline depth in clock edges, counted from the edge that samples x to the edge that updates y. Must equal the instantiated sbox depth.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  input state valid
- in_ready  out  1  block can accept a state
- in_state  in  128  input state; byte i = in_state[127-8i -: 8], FIPS-197 column-major (row i%4, col i/4)
- out_valid  out  1  output state valid
- out_ready  in  1  downstream accepts
- out_state  out  128  SubBytes(+ShiftRows) result, same byte order
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE; feed counter, tag shift register and result-capture flags cleared.
  - out_valid=0, busy=0, in_ready=1 in the cycle after rst deasserts; out_state=0.
  - sbox internal registers are not reset; stale data is ignored because the tags are cleared.
- FSM states IDLE, FEED, DRAIN, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, register in_state, counter=0, go to FEED.
  - FEED: 4 cycles, counter 0..3. Sbox lane r's x is driven combinationally with byte 4*counter+r (column = counter). A tag bit plus the 2-bit column index enters a SBOX_LAT-deep shift register. After counter==3, go to DRAIN.
  - DRAIN: when a tag exits the shift register, capture the 4 sbox y values into the result buffer at the tagged column. After column 3 is captured, go to DONE.
  - DONE: out_valid=1; out_state is held stable until out_valid&&out_ready, then go to IDLE.
- in_ready=0 in FEED, DRAIN and DONE. No overlap between blocks.
- ShiftRows: out byte(row r, col c) = sub byte(row r, col (c+r) mod 4).
- Latency: accept at edge E0 → out_valid high after edge E(4+SBOX_LAT) = E10 for the default.
  - With out_ready tied high, the output handshake occurs at E11 and the next accept at E12.
  - Maximum throughput is one state per 12 cycles.
- Backpressure: out_ready low holds DONE indefinitely. out_state and out_valid stay stable; in_ready stays 0.
- in_valid while in_ready=0 is ignored; upstream must hold its data until the handshake.
- in_state changes after acceptance have no effect, because the state is registered at accept.
- Reset mid-operation (any state): the in-flight block is discarded and no partial out_valid is produced. The next block after reset is processed correctly regardless of sbox residue.

Optional Feature:
- Macro AES_SUB_SHIFT_ROWS_SHIFTROWS_EN.
- Defined: ShiftRows is applied as above.
- Undefined: out_state = SubBytes only, byte-for-byte in input order, for reuse in key expansion.
- Latency, handshake and reset behaviour are identical in both builds.

Test Plan:
- in_state=0 → out_state=0x63636363636363636363636363636363. out_valid rises exactly 10 cycles after the accept edge; busy is high throughout.
- in_state=0x00102030405060708090a0b0c0d0e0f0 with macro defined → out_state=0x6353e08c0960e104cd70b751bacad0e7 (FIPS-197 C.1 round[1].s_row).
- Same input with macro undefined → out_state=0x63cab7040953d051cd60e0e7ba70e18c (round[1].s_box).
- Hold out_ready=0 for 20 cycles after out_valid → out_state unchanged, out_valid=1, in_ready=0. Raise out_ready → one handshake, then in_ready=1 on the next cycle.
- Stream 3 states (0, all 0xFF, the FIPS vector) with in_valid=1 and out_ready=1 throughout:
  - Accepts occur every 12 cycles.
  - Outputs, in order: all 0x63; all 0x16; 0x6353e08c0960e104cd70b751bacad0e7.
- Assert rst for 1 cycle during FEED counter==2 → out_valid stays 0 and in_ready=1 after release. A subsequent state of all 0x53 → out_state all 0xED, with no stray output from the aborted block.
